inst_rom_ctrl: RTL and testbench

INST_ROM_CTRL -- requirements
Module: inst_rom_ctrl

---
 rtl/inst_rom_ctrl_pkg.sv | 24 ++
 rtl/inst_rom_ctrl.sv | 114 +++++++++++
 tb/tb_inst_rom_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/inst_rom_ctrl_pkg.sv
// Shared fetch-path definitions: bus widths, chip/reset levels,
// NOP encoding and the instruction ROM controller state encoding.
package inst_rom_ctrl_pkg;

  localparam int INST_ADDR_W = 16;
  localparam int INST_W      = 16;
  localparam int SRAM_ADDR_W = 18;

  typedef logic [INST_ADDR_W-1:0] inst_addr_bus_t;
  typedef logic [INST_W-1:0]      inst_bus_t;
  typedef logic [SRAM_ADDR_W-1:0] sram_addr_bus_t;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam logic RST_ENABLE   = 1'b1;

  localparam inst_bus_t NOP_INST = 16'h0800;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } rom_state_e;

endpackage

// File: rtl/inst_rom_ctrl.sv
// Instruction fetch controller for an asynchronous external SRAM,
// with programmable read wait states and misaligned-pc trapping.
module inst_rom_ctrl
  import inst_rom_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INST_ADDR_W-1:0] pc,
  input  logic                   ce,
  input  logic                   req_valid,
  output logic                   req_ready,
  output logic [INST_W-1:0]      inst,
  output logic                   resp_valid,
  output logic                   addr_err,
  output logic                   stall_req,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  input  logic [INST_W-1:0]      sram_data_in,
  output logic                   sram_ce_n,
  output logic                   sram_oe_n,
  output logic                   sram_we_n
);

  localparam logic [3:0] WAIT_INIT = WAIT_CYCLES[3:0];

  rom_state_e     state, state_n;
  logic [3:0]     cnt, cnt_n;
  inst_bus_t      inst_q, inst_n;
  logic           rv_q, rv_n;
  logic           ae_q, ae_n;
  sram_addr_bus_t sa_q, sa_n;
  logic           cen_q, cen_n;
  logic           oen_q, oen_n;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state  <= IDLE;
      cnt    <= '0;
      inst_q <= '0;
      rv_q   <= 1'b0;
      ae_q   <= 1'b0;
      sa_q   <= '0;
      cen_q  <= 1'b1;
      oen_q  <= 1'b1;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      inst_q <= inst_n;
      rv_q   <= rv_n;
      ae_q   <= ae_n;
      sa_q   <= sa_n;
      cen_q  <= cen_n;
      oen_q  <= oen_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    inst_n  = inst_q;
    rv_n    = 1'b0;
    ae_n    = 1'b0;
    sa_n    = sa_q;
    cen_n   = cen_q;
    oen_n   = oen_q;
    unique case (state)
      IDLE: begin
        if (req_valid && ce == CHIP_ENABLE) begin
          if (pc[0]) begin
            // Misaligned fetch: answer with a NOP, SRAM untouched
            inst_n = NOP_INST;
            rv_n   = 1'b1;
            ae_n   = 1'b1;
          end else begin
            sa_n    = {3'b000, pc[15:1]};
            cen_n   = 1'b0;
            oen_n   = 1'b0;
            cnt_n   = WAIT_INIT;
            state_n = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (ce != CHIP_ENABLE) begin
          cen_n   = 1'b1;
          oen_n   = 1'b1;
          cnt_n   = '0;
          state_n = IDLE;
        end else if (cnt != '0) begin
          cnt_n = cnt - 4'd1;
        end else begin
          inst_n  = sram_data_in;
          rv_n    = 1'b1;
          cen_n   = 1'b1;
          oen_n   = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign req_ready  = (state == IDLE);
  assign stall_req  = (state == ACCESS);
  assign inst       = inst_q;
  assign resp_valid = rv_q;
  assign addr_err   = ae_q;
  assign sram_addr  = sa_q;
  assign sram_ce_n  = cen_q;
  assign sram_oe_n  = oen_q;
  assign sram_we_n  = 1'b1;

endmodule

// File: tb/tb_inst_rom_ctrl.sv
// Bench: two controllers (2 and 0 wait states) on shared stimulus,
// each scored against a cycle-level model of the fetch protocol.
module tb_inst_rom_ctrl;
  import inst_rom_ctrl_pkg::*;

  localparam int W0 = 2;
  localparam int W1 = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        req_valid;
  logic [15:0] pc;

  logic        req_ready  [2];
  logic [15:0] inst       [2];
  logic        resp_valid [2];
  logic        addr_err   [2];
  logic        stall_req  [2];
  logic [17:0] sram_addr  [2];
  logic [15:0] sram_data  [2];
  logic        sram_ce_n  [2];
  logic        sram_oe_n  [2];
  logic        sram_we_n  [2];

  always #5 clk = ~clk;

  function automatic logic [15:0] word_of(input logic [17:0] a);
    return a[15:0] ^ {a[7:0], a[15:8]} ^ 16'hC3A5 ^ {14'b0, a[17:16]};
  endfunction

  assign sram_data[0] = word_of(sram_addr[0]);
  assign sram_data[1] = word_of(sram_addr[1]);

  inst_rom_ctrl #(.WAIT_CYCLES(W0)) u_dut2 (
    .clk(clk), .rst(rst), .pc(pc), .ce(ce),
    .req_valid(req_valid), .req_ready(req_ready[0]),
    .inst(inst[0]), .resp_valid(resp_valid[0]),
    .addr_err(addr_err[0]), .stall_req(stall_req[0]),
    .sram_addr(sram_addr[0]), .sram_data_in(sram_data[0]),
    .sram_ce_n(sram_ce_n[0]), .sram_oe_n(sram_oe_n[0]),
    .sram_we_n(sram_we_n[0])
  );

  inst_rom_ctrl #(.WAIT_CYCLES(W1)) u_dut0 (
    .clk(clk), .rst(rst), .pc(pc), .ce(ce),
    .req_valid(req_valid), .req_ready(req_ready[1]),
    .inst(inst[1]), .resp_valid(resp_valid[1]),
    .addr_err(addr_err[1]), .stall_req(stall_req[1]),
    .sram_addr(sram_addr[1]), .sram_data_in(sram_data[1]),
    .sram_ce_n(sram_ce_n[1]), .sram_oe_n(sram_oe_n[1]),
    .sram_we_n(sram_we_n[1])
  );

  typedef struct {
    logic [15:0] word;
    logic        err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  logic        busy    [2];
  int          done_at [2];
  logic [17:0] exp_sa  [2];
  logic [15:0] last    [2];
  int          edge_n = 0;
  int          n_cmp  = 0;
  int          n_bad  = 0;

  function automatic int wait_of(input int i);
    return (i == 0) ? W0 : W1;
  endfunction

  task automatic push(input int i, input logic [15:0] w, input logic e);
    exp_t x;
    x.word = w;
    x.err  = e;
    if (i == 0) q0.push_back(x);
    else        q1.push_back(x);
  endtask

  // A fetch of pc occupies the SRAM for wait+1 cycles, then returns word pc/2
  task automatic model_edge(input int i);
    if (rst) begin
      busy[i]   = 1'b0;
      exp_sa[i] = '0;
      last[i]   = '0;
      if (i == 0) q0.delete();
      else        q1.delete();
    end else if (busy[i]) begin
      if (!ce) begin
        busy[i] = 1'b0;
      end else if (edge_n == done_at[i]) begin
        busy[i] = 1'b0;
        last[i] = word_of(exp_sa[i]);
        push(i, last[i], 1'b0);
      end
    end else if (req_valid && ce) begin
      if (pc[0]) begin
        last[i] = 16'h0800;
        push(i, 16'h0800, 1'b1);
      end else begin
        busy[i]    = 1'b1;
        exp_sa[i]  = {3'b000, pc[15:1]};
        done_at[i] = edge_n + wait_of(i) + 1;
      end
    end
  endtask

  initial begin
    busy    = '{1'b0, 1'b0};
    done_at = '{0, 0};
    exp_sa  = '{18'd0, 18'd0};
    last    = '{16'd0, 16'd0};
    forever begin
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      edge_n++;
    end
  end

  task automatic chk(input int i, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL dut%0d %s edge %0d: got %h want %h",
               i, nm, edge_n - 1, act, exp);
    end
  endtask

  task automatic check_dut(input int i);
    exp_t e;
    logic want;
    want  = 1'b0;
    e.word = '0;
    e.err  = 1'b0;
    if (i == 0 && q0.size() > 0) begin
      e = q0.pop_front();
      want = 1'b1;
    end else if (i == 1 && q1.size() > 0) begin
      e = q1.pop_front();
      want = 1'b1;
    end
    chk(i, "resp_valid", 32'(resp_valid[i]), 32'(want));
    chk(i, "addr_err", 32'(addr_err[i]), 32'(want & e.err));
    chk(i, "inst", 32'(inst[i]), 32'(want ? e.word : last[i]));
    chk(i, "req_ready", 32'(req_ready[i]), 32'(!busy[i]));
    chk(i, "stall_req", 32'(stall_req[i]), 32'(busy[i]));
    chk(i, "sram_ce_n", 32'(sram_ce_n[i]), 32'(!busy[i]));
    chk(i, "sram_oe_n", 32'(sram_oe_n[i]), 32'(!busy[i]));
    chk(i, "sram_we_n", 32'(sram_we_n[i]), 32'd1);
    chk(i, "sram_addr", 32'(sram_addr[i]), 32'(exp_sa[i]));
  endtask

  initial forever begin
    @(negedge clk);
    check_dut(0);
    check_dut(1);
  end

  task automatic drive(input logic r, input logic c,
                       input logic v, input logic [15:0] p);
    rst       = r;
    ce        = c;
    req_valid = v;
    pc        = p;
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] p;
    rst       = 1'b1;
    ce        = 1'b0;
    req_valid = 1'b0;
    pc        = '0;
    drive(1, 0, 0, 16'h0000);
    drive(1, 0, 0, 16'h0000);
    drive(0, 1, 0, 16'h0000);
    // aligned fetch of 0x0010
    drive(0, 1, 1, 16'h0010);
    repeat (5) drive(0, 1, 0, 16'h0000);
    // back-to-back fetches
    drive(0, 1, 1, 16'h0000);
    drive(0, 1, 1, 16'h0002);
    drive(0, 1, 1, 16'h0002);
    repeat (5) drive(0, 1, 0, 16'h0000);
    // misaligned fetch
    drive(0, 1, 1, 16'h0003);
    repeat (2) drive(0, 1, 0, 16'h0000);
    // ce dropped in the second access cycle
    drive(0, 1, 1, 16'h0020);
    drive(0, 1, 0, 16'h0000);
    drive(0, 0, 0, 16'h0000);
    repeat (3) drive(0, 1, 0, 16'h0000);
    // reset in the middle of an access
    drive(0, 1, 1, 16'h0040);
    drive(1, 1, 0, 16'h0000);
    drive(0, 1, 1, 16'h0042);
    repeat (5) drive(0, 1, 0, 16'h0000);
    repeat (800) begin
      p = 16'($urandom);
      if ($urandom_range(0, 3) != 0) p[0] = 1'b0;
      drive(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 9) != 0),
            1'($urandom_range(0, 1)), p);
    end
    repeat (30) drive(0, 1, 0, 16'h0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
